// File: rtl/genesis_pad_scanner.sv
// genesis_pad_scanner
//
// Autonomous reader for a SEGA Genesis 3-/6-button pad on the DB-9 port.
// The scanner drives the select line itself and repeats one frame at a time:
//   1. an idle poll gap with select held high;
//   2. a train of select half-phases (8 for the 6-button sequence, 2 otherwise),
//      with the pins sampled on the last cycle of each relevant phase;
//   3. a single evaluation cycle that debounces whole frames before
//      publishing them.
// The 6-button pad announces itself on the third select-low phase (P4) by
// pulling all four direction pins low. On the following high phase (P5) it
// reports Z/Y/X/Mode on those pins.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-low reset
//   pad_up..pad_tr  raw DB-9 inputs, active-low, asynchronous
//   pad_select   registered select drive (pin 7)
//   buttons_out  debounced buttons, 1 = pressed
//                [0]Up [1]Down [2]Left [3]Right [4]A [5]Start
//                [6]Z [7]Y [8]X [9]B [10]C [11]Mode
//   pad_present  pad detected in the last accepted frame
//   six_button   6-button pad detected in the last accepted frame
//   frame_valid  one-cycle pulse after every completed frame
module genesis_pad_scanner #(
  parameter int SEL_HALF_CYCLES = 500,
  parameter int POLL_CYCLES     = 800000,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int ENABLE_6BTN     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pad_up,
  input  logic        pad_down,
  input  logic        pad_left,
  input  logic        pad_right,
  input  logic        pad_tl,
  input  logic        pad_tr,
  output logic        pad_select,
  output logic [11:0] buttons_out,
  output logic        pad_present,
  output logic        six_button,
  output logic        frame_valid
);

  localparam int NPH    = (ENABLE_6BTN != 0) ? 8 : 2;
  localparam int IDLE_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PH_W   = $clog2(SEL_HALF_CYCLES);
  localparam int IDX_W  = $clog2(NPH);
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SEL_HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NPH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_EVAL  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nx;
  logic [PH_W-1:0]     phase_cnt, phase_cnt_nx;
  logic [IDX_W-1:0]    phase_idx, phase_idx_nx;
  logic                sel_nx;
  logic                sample_en;
  logic                eval_en;

  // pins packed as {tr, tl, right, left, down, up}, still active-low
  logic [5:0]          pins_p0, pins_p1;

  // per-phase captures, active-high
  logic                s_a, s_start, s_present;
  logic                s_up, s_down, s_left, s_right, s_b, s_c;
  logic                s_six_ind;
  logic                s_z, s_y, s_x, s_mode;

  // candidate packed as {six, present, buttons[11:0]}
  logic [13:0]         cand, prev_cand;
  logic [CNT_W-1:0]    match_cnt, match_nx, cnt_inc;

  // ---- stage p0/p1: two-flop synchronizer for the raw pad pins
  always_ff @(posedge clk) begin
    pins_p0 <= {pad_tr, pad_tl, pad_right, pad_left, pad_down, pad_up};
    pins_p1 <= pins_p0;
  end

  // ---- sequencing FSM
  always_comb begin
    state_nx     = state;
    idle_cnt_nx  = idle_cnt;
    phase_cnt_nx = phase_cnt;
    phase_idx_nx = phase_idx;
    sample_en    = 1'b0;
    eval_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (idle_cnt == IDLE_LAST) begin
          state_nx     = ST_PHASE;
          idle_cnt_nx  = '0;
          phase_cnt_nx = '0;
          phase_idx_nx = '0;
        end else begin
          idle_cnt_nx = idle_cnt + IDLE_W'(1);
        end
      end
      ST_PHASE: begin
        if (phase_cnt == PH_LAST) begin
          sample_en    = 1'b1;
          phase_cnt_nx = '0;
          if (phase_idx == IDX_LAST) begin
            state_nx     = ST_EVAL;
            phase_idx_nx = '0;
          end else begin
            phase_idx_nx = phase_idx + IDX_W'(1);
          end
        end else begin
          phase_cnt_nx = phase_cnt + PH_W'(1);
        end
      end
      ST_EVAL: begin
        eval_en     = 1'b1;
        state_nx    = ST_IDLE;
        idle_cnt_nx = '0;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // select follows the state being entered so the pin is a clean register;
    // even phases drive it low, odd phases and idle drive it high
    sel_nx = (state_nx == ST_PHASE) ? phase_idx_nx[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idle_cnt   <= '0;
      phase_cnt  <= '0;
      phase_idx  <= '0;
      pad_select <= 1'b1;
    end else begin
      state      <= state_nx;
      idle_cnt   <= idle_cnt_nx;
      phase_cnt  <= phase_cnt_nx;
      phase_idx  <= phase_idx_nx;
      pad_select <= sel_nx;
    end
  end

  // ---- stage p2: per-phase sampling of the synchronized pins
  always_ff @(posedge clk) begin
    if (sample_en) begin
      if (int'(phase_idx) == 0) begin
        s_a       <= ~pins_p1[4];
        s_start   <= ~pins_p1[5];
        s_present <= ~pins_p1[2] & ~pins_p1[3];
      end
      if (int'(phase_idx) == 1) begin
        s_up    <= ~pins_p1[0];
        s_down  <= ~pins_p1[1];
        s_left  <= ~pins_p1[2];
        s_right <= ~pins_p1[3];
        s_b     <= ~pins_p1[4];
        s_c     <= ~pins_p1[5];
      end
      if ((ENABLE_6BTN != 0) && (int'(phase_idx) == 4)) begin
        s_six_ind <= ~|pins_p1[3:0];
      end
      if ((ENABLE_6BTN != 0) && (int'(phase_idx) == 5)) begin
        s_z    <= ~pins_p1[0];
        s_y    <= ~pins_p1[1];
        s_x    <= ~pins_p1[2];
        s_mode <= ~pins_p1[3];
      end
    end
  end

  // Candidate assembly: a missing pad reads as all zeros, and a 3-button pad
  // never reports the 6-button-only bits.
  always_comb begin
    cand = '0;
    if (s_present) begin
      cand[0]  = s_up;
      cand[1]  = s_down;
      cand[2]  = s_left;
      cand[3]  = s_right;
      cand[4]  = s_a;
      cand[5]  = s_start;
      cand[9]  = s_b;
      cand[10] = s_c;
      cand[12] = 1'b1;
      if ((ENABLE_6BTN != 0) && s_six_ind) begin
        cand[6]  = s_z;
        cand[7]  = s_y;
        cand[8]  = s_x;
        cand[11] = s_mode;
        cand[13] = 1'b1;
      end
    end
  end

  // Saturating run-length of identical frames; a changed frame restarts at 1.
  always_comb begin
    cnt_inc  = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + CNT_W'(1);
    match_nx = (cand == prev_cand) ? cnt_inc : CNT_W'(1);
  end

  // ---- stage p3: frame evaluation and output publication
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cand   <= '0;
      match_cnt   <= '0;
      buttons_out <= '0;
      pad_present <= 1'b0;
      six_button  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= eval_en;
      if (eval_en) begin
        prev_cand <= cand;
        match_cnt <= match_nx;
        if (match_nx == CNT_MAX) begin
          buttons_out <= cand[11:0];
          pad_present <= cand[12];
          six_button  <= cand[13];
        end
      end
    end
  end

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Bench for genesis_pad_scanner with a behavioural Genesis pad attached.
module tb_genesis_pad_scanner;

  localparam int S  = 4;
  localparam int P  = 16;
  localparam int D  = 2;
  localparam int FR = P + 8 * S + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pad_up, pad_down, pad_left, pad_right, pad_tl, pad_tr;
  logic        pad_select;
  logic [11:0] buttons_out;
  logic        pad_present, six_button, frame_valid;

  int          checks = 0;
  int          errors = 0;

  // pad configuration: type 0 = unplugged, 3 = 3-button, 6 = 6-button
  int          pad_type = 0;
  logic [11:0] pad_btn = '0;

  always #5 clk = ~clk;

  genesis_pad_scanner #(
    .SEL_HALF_CYCLES(S),
    .POLL_CYCLES(P),
    .DEBOUNCE_FRAMES(D),
    .ENABLE_6BTN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pad_up(pad_up),
    .pad_down(pad_down),
    .pad_left(pad_left),
    .pad_right(pad_right),
    .pad_tl(pad_tl),
    .pad_tr(pad_tr),
    .pad_select(pad_select),
    .buttons_out(buttons_out),
    .pad_present(pad_present),
    .six_button(six_button),
    .frame_valid(frame_valid)
  );

  // Pad model: counts select falling edges; a long high stretch restarts the
  // count, as the real pad's internal timeout does.
  logic sel_prev = 1'b1;
  int   hi_cnt = 0;
  int   fall_cnt = 0;

  always @(posedge clk) begin
    sel_prev <= pad_select;
    hi_cnt   <= pad_select ? hi_cnt + 1 : 0;
    if (sel_prev && !pad_select) fall_cnt <= (hi_cnt > 8) ? 1 : fall_cnt + 1;
  end

  always_comb begin
    pad_up = 1'b1; pad_down = 1'b1; pad_left = 1'b1; pad_right = 1'b1;
    pad_tl = 1'b1; pad_tr = 1'b1;
    if (pad_type != 0) begin
      if (!pad_select) begin
        if (pad_type == 6 && fall_cnt == 3) begin
          pad_up = 1'b0; pad_down = 1'b0; pad_left = 1'b0; pad_right = 1'b0;
        end else begin
          pad_up = ~pad_btn[0]; pad_down = ~pad_btn[1];
          pad_left = 1'b0; pad_right = 1'b0;
        end
        pad_tl = ~pad_btn[4];
        pad_tr = ~pad_btn[5];
      end else begin
        if (pad_type == 6 && fall_cnt == 3) begin
          pad_up = ~pad_btn[6]; pad_down = ~pad_btn[7];
          pad_left = ~pad_btn[8]; pad_right = ~pad_btn[11];
        end else begin
          pad_up = ~pad_btn[0]; pad_down = ~pad_btn[1];
          pad_left = ~pad_btn[2]; pad_right = ~pad_btn[3];
        end
        pad_tl = ~pad_btn[9];
        pad_tr = ~pad_btn[10];
      end
    end
  end

  // What a frame should report for a given pad, packed {six, present, buttons}.
  function automatic logic [13:0] frame_of(int t, logic [11:0] b);
    if (t == 0) return 14'h0000;
    if (t == 3) return {2'b01, b & 12'h63F};
    return {2'b11, b};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Waits for the next frame_valid, counting cycles and select falling edges.
  task automatic wait_fv(output int cyc, output int falls);
    logic prev;
    logic seen;
    prev  = pad_select;
    cyc   = 0;
    falls = 0;
    seen  = 1'b0;
    for (int i = 0; i < 4 * FR && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev && !pad_select) falls++;
      prev = pad_select;
      if (frame_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_valid_timeout: got no pulse, expected one within %0d cycles", 4 * FR);
    end
  endtask

  // Releases reset just after an edge and checks the first select fall.
  task automatic release_and_check_fall(string tag);
    reset = 1'b1;
    for (int i = 1; i <= P; i++) begin
      @(posedge clk);
      #1;
      if (i == P - 1) check({tag, "_sel_before_fall"}, 32'(pad_select), 32'd1);
      if (i == P)     check({tag, "_first_fall"}, 32'(pad_select), 32'd0);
    end
  endtask

  typedef struct {
    int          ptype;
    logic [11:0] btn;
    logic [11:0] exp_btn;
    logic        exp_pres;
    logic        exp_six;
  } vec_t;

  vec_t        tbl[6];
  int          cyc, falls;
  logic [13:0] hist[$];
  logic [13:0] exp_out;
  logic [13:0] prev_exp;
  logic        fv_seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{3, 12'h410, 12'h410, 1'b1, 1'b0};
    tbl[1] = '{6, 12'h900, 12'h900, 1'b1, 1'b1};
    tbl[2] = '{3, 12'hFFE, 12'h63E, 1'b1, 1'b0};
    tbl[3] = '{6, 12'hFFF, 12'hFFF, 1'b1, 1'b1};
    tbl[4] = '{6, 12'h000, 12'h000, 1'b1, 1'b1};
    tbl[5] = '{0, 12'hFFF, 12'h000, 1'b0, 1'b0};

    // reset state
    pad_type = 0;
    pad_btn  = '0;
    reset    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_select", 32'(pad_select), 32'd1);
    check("rst_buttons", 32'(buttons_out), 32'd0);
    check("rst_flags", {30'd0, six_button, pad_present}, 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    release_and_check_fall("rst");

    // first frame completes the remaining phases plus eval, then full periods
    wait_fv(cyc, falls);
    check("first_frame_latency", 32'(cyc), 32'(FR - P));
    check("nopad_buttons_f1", 32'(buttons_out), 32'd0);
    wait_fv(cyc, falls);
    check("frame_period", 32'(cyc), 32'(FR));
    check("select_falls_per_frame", 32'(falls), 32'd4);
    check("nopad_buttons_f2", 32'(buttons_out), 32'd0);
    check("nopad_flags_f2", {30'd0, six_button, pad_present}, 32'd0);

    // table: each pad state needs two frames to be accepted
    for (int i = 0; i < 6; i++) begin
      pad_type = tbl[i].ptype;
      pad_btn  = tbl[i].btn;
      prev_exp = (i == 0) ? 14'h0 :
                 {tbl[i-1].exp_six, tbl[i-1].exp_pres, tbl[i-1].exp_btn};
      wait_fv(cyc, falls);
      check($sformatf("tbl%0d_hold", i), {18'd0, six_button, pad_present, buttons_out},
            {18'd0, prev_exp});
      wait_fv(cyc, falls);
      check($sformatf("tbl%0d_period", i), 32'(cyc), 32'(FR));
      check($sformatf("tbl%0d_buttons", i), 32'(buttons_out), 32'(tbl[i].exp_btn));
      check($sformatf("tbl%0d_present", i), 32'(pad_present), 32'(tbl[i].exp_pres));
      check($sformatf("tbl%0d_six", i), 32'(six_button), 32'(tbl[i].exp_six));
    end

    // reset in the middle of PHASE(3)
    pad_type = 6;
    pad_btn  = 12'hFFF;
    wait_fv(cyc, falls);
    wait_fv(cyc, falls);
    check("pre_reset_buttons", 32'(buttons_out), 32'hFFF);
    repeat (P + 3 * S + 1) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_select", 32'(pad_select), 32'd1);
    check("midrst_buttons", 32'(buttons_out), 32'd0);
    check("midrst_flags", {30'd0, six_button, pad_present}, 32'd0);
    fv_seen = frame_valid;
    repeat (3) begin
      @(posedge clk);
      #1;
      fv_seen = fv_seen | frame_valid;
    end
    check("midrst_no_frame_valid", 32'(fv_seen), 32'd0);
    release_and_check_fall("midrst");
    wait_fv(cyc, falls);
    check("midrst_first_frame", 32'(cyc), 32'(FR - P));
    check("midrst_no_early_update", 32'(buttons_out), 32'd0);

    // debounce: Start toggles every frame, then is held
    pad_type = 3;
    for (int k = 1; k <= 6; k++) begin
      pad_btn = (k % 2 == 1) ? 12'h020 : 12'h000;
      wait_fv(cyc, falls);
      check($sformatf("toggle_f%0d", k), 32'(buttons_out), 32'd0);
    end
    pad_btn = 12'h020;
    wait_fv(cyc, falls);
    check("held_f1", 32'(buttons_out), 32'd0);
    wait_fv(cyc, falls);
    check("held_f2", 32'(buttons_out), 32'h020);
    check("held_present", 32'(pad_present), 32'd1);

    // randomized pads against the frame-history model
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hist.delete();
    exp_out = '0;
    pad_type = 6;
    pad_btn  = 12'(($urandom));
    reset = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic all_eq;
      wait_fv(cyc, falls);
      hist.push_back(frame_of(pad_type, pad_btn));
      if (hist.size() >= D) begin
        all_eq = 1'b1;
        for (int j = 1; j < D; j++)
          if (hist[hist.size() - 1 - j] != hist[hist.size() - 1]) all_eq = 1'b0;
        if (all_eq) exp_out = hist[hist.size() - 1];
      end
      check($sformatf("rand_f%0d", f), {18'd0, six_button, pad_present, buttons_out},
            {18'd0, exp_out});
      if ($urandom_range(1) == 1) begin
        case ($urandom_range(2))
          0: pad_type = 0;
          1: pad_type = 3;
          default: pad_type = 6;
        endcase
        pad_btn = 12'($urandom);
        // a 3-button pad cannot press Up and Down together
        if (pad_type == 3 && pad_btn[0] && pad_btn[1]) pad_btn[1] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
